// File: rtl/run_bit_tx_pkg.sv
// Shared definitions for the run-length serial transmitter.
//   state_t : transmitter FSM states
//   cmd_t   : one run-length command {bit value, run length}
//   *_DEF   : default parameter values used by run_bit_tx / run_tracker
package run_bit_tx_pkg;

  localparam int   LEN_W_DEF    = 4;
  localparam int   RUN_TH_DEF   = 4;
  localparam logic IDLE_BIT_DEF = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // The pending slot stores commands in this form; len is sized at the
  // package width, so instances keep LEN_W at LEN_W_DEF.
  typedef struct packed {
    logic                 val;
    logic [LEN_W_DEF-1:0] len;
  } cmd_t;

endpackage

// File: rtl/run_tracker.sv
// Saturating run counter over the serial stream.
//   clk, reset : clock, synchronous active-low reset
//   nb         : bit that will be on the line after this edge
//   run_cnt    : length of the current run of identical bits, saturates at RUN_TH
//   run_hit    : run_cnt has reached RUN_TH (registered, aligned with the bit)
module run_tracker
  import run_bit_tx_pkg::*;
#(
  parameter int RUN_TH = RUN_TH_DEF,
  parameter int CNT_W  = $clog2(RUN_TH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             nb,
  output logic             run_hit,
  output logic [CNT_W-1:0] run_cnt
);

  logic             prev;
  logic [CNT_W-1:0] cnt_nxt;

  // run_cnt==0 only right after reset, so prev's value is irrelevant then.
  always_comb begin
    cnt_nxt = CNT_W'(1);
    if (run_cnt != '0 && nb == prev)
      cnt_nxt = (run_cnt == CNT_W'(RUN_TH)) ? run_cnt : run_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev    <= 1'b0;
      run_cnt <= '0;
      run_hit <= 1'b0;
    end else begin
      prev    <= nb;
      run_cnt <= cnt_nxt;
      run_hit <= (cnt_nxt >= CNT_W'(RUN_TH));
    end
  end

endmodule

// File: rtl/run_bit_tx.sv
// Run-length serial bit transmitter.
//   clk, reset : clock, synchronous active-low reset
//   cmd_valid/cmd_ready : command handshake; cmd_bit, cmd_len = run to send
//   out_valid  : out_bit belongs to a commanded run
//   out_bit    : registered serial bit (IDLE_BIT between runs)
//   run_hit    : out_bit completes/extends a run of >= RUN_TH identical bits
// One command can wait in a pending slot while a run is sent, so runs
// follow each other without gaps.
module run_bit_tx
  import run_bit_tx_pkg::*;
#(
  parameter int   LEN_W    = LEN_W_DEF,
  parameter int   RUN_TH   = RUN_TH_DEF,
  parameter logic IDLE_BIT = IDLE_BIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_bit,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             out_valid,
  output logic             out_bit,
  output logic             run_hit
);

  localparam int CNT_W = $clog2(RUN_TH + 1);

  state_t           state;
  cmd_t             pend;
  logic             pend_valid;
  logic [LEN_W-1:0] rem;
  logic [CNT_W-1:0] run_cnt;
  logic             acc, take, load_pt, nb;

  assign cmd_ready = reset && !pend_valid;
  assign acc       = cmd_valid && cmd_ready;
  // Zero-length commands are accepted but never reach the line.
  assign take      = acc && (cmd_len != '0);
  assign load_pt   = (state == IDLE) || (state == SEND && rem == LEN_W'(1));

  // Next line bit; also feeds the run tracker so run_hit lines up with out_bit.
  always_comb begin
    nb = out_bit;
    if (load_pt) begin
      if (pend_valid)  nb = pend.val;
      else if (take)   nb = cmd_bit;
      else             nb = IDLE_BIT;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      pend       <= '0;
      pend_valid <= 1'b0;
      rem        <= '0;
      out_valid  <= 1'b0;
      out_bit    <= IDLE_BIT;
    end else if (load_pt) begin
      if (pend_valid) begin
        state      <= SEND;
        out_valid  <= 1'b1;
        out_bit    <= pend.val;
        rem        <= LEN_W'(pend.len);
        pend_valid <= 1'b0;
      end else if (take) begin
        // bypass: pending is empty, start the just-accepted run directly
        state     <= SEND;
        out_valid <= 1'b1;
        out_bit   <= cmd_bit;
        rem       <= cmd_len;
      end else begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_bit   <= IDLE_BIT;
        rem       <= '0;
      end
    end else begin
      rem <= rem - LEN_W'(1);
      if (take) begin
        pend_valid <= 1'b1;
        pend       <= '{val: cmd_bit, len: LEN_W_DEF'(cmd_len)};
      end
    end
  end

  run_tracker #(.RUN_TH(RUN_TH), .CNT_W(CNT_W)) u_trk (
    .clk     (clk),
    .reset   (reset),
    .nb      (nb),
    .run_hit (run_hit),
    .run_cnt (run_cnt)
  );

  // run_hit and run_cnt are registered together and must agree.
  a_hit_cnt: assert property (@(posedge clk) disable iff (!reset)
    run_hit == (run_cnt == CNT_W'(RUN_TH)));

endmodule

// File: tb/tb_run_bit_tx.sv
module tb_run_bit_tx;
  import run_bit_tx_pkg::*;

  localparam int LEN_W  = 4;
  localparam int RUN_TH = 4;

  logic clk = 1'b0, reset = 1'b0, cmd_valid = 1'b0, cmd_bit = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic cmd_ready, out_valid, out_bit, run_hit;

  run_bit_tx #(.LEN_W(LEN_W), .RUN_TH(RUN_TH), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_bit(cmd_bit), .cmd_len(cmd_len), .out_valid(out_valid),
    .out_bit(out_bit), .run_hit(run_hit)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // q: runs still to be shown; q[0] is on the line, left counts its
  // remaining bits including the one shown. More than one entry means
  // a command is waiting, so no new command can be taken.
  typedef struct { logic b; int left; } run_t;
  run_t q[$];
  logic hist[$];          // last RUN_TH line bits since reset
  bit   started = 0;
  logic exp_valid = 0, exp_bit = 0, exp_hit = 0;
  logic m_acc;
  run_t nr;

  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      hist.delete();
      started = 1;
    end else begin
      m_acc = cmd_valid && (q.size() <= 1);
      if (q.size() > 0) begin
        q[0].left = q[0].left - 1;
        if (q[0].left == 0) void'(q.pop_front());
      end
      if (m_acc && cmd_len != 0) begin
        nr.b = cmd_bit;
        nr.left = int'(cmd_len);
        q.push_back(nr);
      end
      hist.push_back(q.size() > 0 ? q[0].b : 1'b0);
      if (hist.size() > RUN_TH) void'(hist.pop_front());
    end
    exp_valid = (q.size() > 0);
    exp_bit   = (q.size() > 0) ? q[0].b : 1'b0;
    exp_hit   = (hist.size() == RUN_TH);
    for (int i = 1; i < hist.size(); i++)
      if (hist[i] != hist[0]) exp_hit = 1'b0;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_out_valid", out_valid, exp_valid);
      chk("m_out_bit",   out_bit,   exp_bit);
      chk("m_run_hit",   run_hit,   exp_hit);
      chk("m_cmd_ready", cmd_ready, reset && (q.size() <= 1));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic drive(input logic v, input logic b, input logic [LEN_W-1:0] l);
    cmd_valid = v; cmd_bit = b; cmd_len = l;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Literal expectations, written in display order (leftmost = first cycle
  // after the next rising edge).
  task automatic watch(input string nm, input int n, input logic [31:0] eb,
                       input logic [31:0] ev, input logic [31:0] eh, input logic [31:0] er);
    @(posedge clk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({nm, "_bit"},   out_bit,   eb[n-1-i]);
      chk({nm, "_valid"}, out_valid, ev[n-1-i]);
      chk({nm, "_hit"},   run_hit,   eh[n-1-i]);
      chk({nm, "_ready"}, cmd_ready, er[n-1-i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_bit",   out_bit,   1'b0);
    chk("rst_hit",   run_hit,   1'b0);
    @(posedge clk); #1 reset = 1'b1;

    // idle after reset: hit on 4th idle bit
    watch("idle", 5, 5'b00000, 5'b00000, 5'b00011, 5'b11111);

    // {1,3} then {0,1} waiting in pending
    step();
    fork
      begin
        drive(1, 1, 3); step(); drive(0, 0, 0); step();
        drive(1, 0, 1); step(); drive(0, 0, 0);
      end
      watch("b2b", 6, 6'b111000, 6'b111100, 6'b000000, 6'b110111);
    join

    // {1,6}, then idle zeros
    step();
    fork
      begin drive(1, 1, 6); step(); drive(0, 0, 0); end
      watch("len6", 10, 10'b1111110000, 10'b1111110000, 10'b0001110001, 10'b1111111111);
    join

    // {1,2} {0,0} {1,2}: empty run discarded, ones contiguous
    step();
    fork
      begin
        drive(1, 1, 2); step(); drive(1, 0, 0); step();
        drive(1, 1, 2); step(); drive(0, 0, 0);
      end
      watch("zero", 6, 6'b111100, 6'b111100, 6'b000100, 6'b111111);
    join

    // max length run
    step();
    fork
      begin drive(1, 1, 15); step(); drive(0, 0, 0); end
      watch("max", 17, 17'b11111111111111100, 17'b11111111111111100,
            17'b00011111111111100, 17'h1FFFF);
    join

    // reset on the 2nd bit of {1,5} with {0,3} pending
    step();
    fork
      begin
        drive(1, 1, 5); step(); drive(1, 0, 3); step();
        drive(0, 0, 0); reset = 1'b0; step(); reset = 1'b1;
      end
      watch("midrst", 8, 8'b11000000, 8'b11000000, 8'b00000011, 8'b10111111);
    join

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/run_bit_tx.md
Name: run_bit_tx

Overview:
- Serial bit-stream transmitter: the stimulus-generating counterpart of the team's run-of-identical-bits detector FSMs.
- Accepts run-length commands (bit value, length) over a valid/ready handshake and drives one serial bit per clock.
- Produces the same "RUN_TH identical consecutive bits" flag a detector would, one-for-one with each driven bit, so a bench can compare the detector against it directly.
- Sits upstream of a detector's serial `in` in the test/demo harness.

Parameters:
- LEN_W, 4: width of the run-length field; maximum run is 2^LEN_W-1 bits.
- RUN_TH, 4: consecutive identical bits needed to raise run_hit.
- IDLE_BIT, 0: level driven on out_bit when no run is active.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command can be taken this cycle.
- cmd_bit  input  1  bit value of the run.
- cmd_len  input  LEN_W  run length in bits; 0 means an empty run.
- out_valid  output  1  out_bit belongs to a commanded run.
- out_bit  output  1  serial bit; registered.
- run_hit  output  1  high in the cycle where out_bit completes or extends a run of >= RUN_TH identical bits; registered, aligned with out_bit.

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE; pending slot empties.
  - Outputs: out_valid=0, out_bit=IDLE_BIT, rem=0, run_cnt=0, run_hit=0.
  - cmd_ready is forced to 0 while reset is low.
  - A reset mid-run drops the current run and any pending command with no further bits.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready at an edge.
  - cmd_ready = !pend_valid, a combinational decode of a register (no dependency on cmd_valid).
  - A command with cmd_len==0 is accepted and discarded; it never occupies pending and emits nothing.
- States:
  - IDLE: out_valid=0, out_bit=IDLE_BIT.
  - SEND: out_valid=1, out_bit=cur_bit; rem counts bits left including the current one.
- Load point: an edge where state==IDLE, or where state==SEND && rem==1. The next source is chosen in this priority order:
  - (a) pending slot if valid;
  - (b) else the command accepted at this edge, if cmd_len!=0 (bypass);
  - (c) else go to IDLE.
  - On a load: out_bit<=bit, rem<=len, state<=SEND, and the pending slot clears if it was used.
- Not a load point (SEND, rem>1): rem<=rem-1. A command accepted at this edge is written to pending.
- Latency:
  - From IDLE, the first bit appears on out_bit the cycle after acceptance.
  - Back-to-back runs (pending or bypass) are gapless: the bit after the last bit of run N is the first bit of run N+1.
- Simultaneous events: a pending command can never coexist with an acceptance, because cmd_ready=0 whenever pending is valid. No arbitration beyond the priority above.
- Run tracking, evaluated every edge on the next out_bit value nb, including idle cycles:
  - run_cnt <= (run_cnt!=0 && nb==out_bit) ? min(run_cnt+1, RUN_TH) : 1.
  - run_hit <= (next run_cnt >= RUN_TH).
  - run_cnt saturates at RUN_TH and never wraps.
  - Idle bits count as bits, matching a detector that samples every cycle.
- Widths: rem is LEN_W bits. run_cnt is clog2(RUN_TH+1) bits.

Decomposition:
- Shared package: state enum (IDLE, SEND); the command struct {bit, len[LEN_W-1:0]}; RUN_TH and IDLE_BIT defaults.
- Sub-module run_tracker (params RUN_TH; inputs clk, reset, nb; outputs run_hit, run_cnt): the saturating run counter.
- The top level holds the FSM, the pending slot, and the rem counter.

Test Plan:
- Reset pulse, then 5 idle cycles -> out_valid=0, out_bit=0 throughout; cmd_ready=0 during reset and 1 after; run_hit rises on the 4th idle cycle after reset and stays 1.
- From IDLE, cmd {1,3} then {0,1} back-to-back -> out_bit 1,1,1,0 gapless with out_valid=1; run_hit never 1 during the ones; cmd_ready low for one cycle while the second command waits in pending.
- cmd {1,6} -> six 1s; run_hit=0,0,0,1,1,1; then idle 0s with run_hit=0 until the 4th idle 0.
- cmd {0,0} between {1,2} and {1,2} -> discarded; out_bit 1,1,1,1 contiguous; run_hit=1 on the 4th bit.
- Max length {1,15} -> exactly 15 bits; rem wraps to IDLE with no extra bit.
- reset=0 asserted on the 2nd bit of {1,5} with {0,3} pending -> the next cycle shows out_valid=0, out_bit=0, run_hit=0; the pending command is never emitted.
